time_keeper: RTL and testbench

- Time-of-day and alarm core of the alarm clock. Keeps hours, minutes and seconds from a divided system clock.
- Handles time-set and alarm-set modes from debounced button pulses and drives the alarm ringing output.
- Produces the 17-bit seconds-of-day value (0..86399) consumed by display_ctrl on its disp_time input.

---
 rtl/time_keeper.sv | 185 ++++++++++++++++++
 tb/tb_time_keeper.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// Time-of-day and alarm core: prescaled h/m/s counter, set modes, alarm compare and ring control.
// disp_time is the registered seconds-of-day (time, or alarm while in SET_ALARM).
`timescale 1ns/1ps
module time_keeper #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int RING_SECS = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_hr,
    input  logic        btn_min,
    input  logic        btn_stop,
    output logic [16:0] disp_time,
    output logic [1:0]  mode,
    output logic        ringing
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);

    typedef enum logic [1:0] {
        M_RUN       = 2'd0,
        M_SET_TIME  = 2'd1,
        M_SET_ALARM = 2'd2
    } mode_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RING = 1'b1
    } ring_t;

    function automatic logic [4:0] inc_24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] inc_60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [16:0] to_secs(input logic [4:0] h, input logic [5:0] m,
                                            input logic [5:0] s);
        return ({12'd0, h} * 17'd3600) + ({11'd0, m} * 17'd60) + {11'd0, s};
    endfunction

    mode_t           r_mode, w_mode_nxt;
    ring_t           r_ring, w_ring_nxt;
    logic [PW-1:0]   r_presc, w_presc_nxt;
    logic [RW-1:0]   r_ring_cnt, w_ring_cnt_nxt;
    logic [4:0]      r_h, r_ah, w_h_nxt, w_ah_nxt, w_h_inc;
    logic [5:0]      r_m, r_s, r_am, w_m_nxt, w_s_nxt, w_am_nxt, w_m_inc, w_s_inc;
    logic [16:0]     r_disp;
    logic            w_tick;
    logic            w_match;

    // Prescaler never runs in SET_TIME, so no tick can arrive there.
    assign w_tick = (r_mode != M_SET_TIME) && (r_presc == PRESC_MAX);

    always_comb begin
        w_s_inc = r_s;
        w_m_inc = r_m;
        w_h_inc = r_h;
        if (w_tick) begin
            w_s_inc = inc_60(r_s);
            if (r_s == 6'd59) begin
                w_m_inc = inc_60(r_m);
                if (r_m == 6'd59) begin
                    w_h_inc = inc_24(r_h);
                end
            end
        end
    end

    // Match is judged on the post-tick time: the counter has just rolled into the alarm minute.
    assign w_match = w_tick && (r_mode == M_RUN) && (w_h_inc == r_ah) &&
                     (w_m_inc == r_am) && (w_s_inc == 6'd0);

    always_comb begin
        w_mode_nxt  = r_mode;
        w_h_nxt     = w_h_inc;
        w_m_nxt     = w_m_inc;
        w_s_nxt     = w_s_inc;
        w_ah_nxt    = r_ah;
        w_am_nxt    = r_am;
        w_presc_nxt = (r_presc == PRESC_MAX) ? '0 : r_presc + PW'(1);
        case (r_mode)
            M_RUN: begin
                if (btn_mode) begin
                    w_mode_nxt = M_SET_TIME;
                    w_s_nxt    = '0;
                end
            end
            M_SET_TIME: begin
                if (btn_mode) begin
                    w_mode_nxt = M_SET_ALARM;
                end else if (btn_hr) begin
                    w_h_nxt = inc_24(r_h);
                end else if (btn_min) begin
                    w_m_nxt = inc_60(r_m);
                end
            end
            M_SET_ALARM: begin
                if (btn_mode) begin
                    w_mode_nxt = M_RUN;
                end else if (btn_hr) begin
                    w_ah_nxt = inc_24(r_ah);
                end else if (btn_min) begin
                    w_am_nxt = inc_60(r_am);
                end
            end
            default: w_mode_nxt = M_RUN;
        endcase
        // Holding at 0 on the leaving edge too makes the first tick land CLK_FREQ cycles later.
        if ((r_mode == M_SET_TIME) || (w_mode_nxt == M_SET_TIME)) begin
            w_presc_nxt = '0;
        end
    end

    always_comb begin
        w_ring_nxt     = r_ring;
        w_ring_cnt_nxt = r_ring_cnt;
        case (r_ring)
            R_IDLE: begin
                if (w_match) begin
                    w_ring_nxt     = R_RING;
                    w_ring_cnt_nxt = '0;
                end
            end
            R_RING: begin
                if (btn_stop || btn_mode) begin
                    w_ring_nxt = R_IDLE;
                end else if (w_tick) begin
                    if (r_ring_cnt == RING_LAST) begin
                        w_ring_nxt = R_IDLE;
                    end else begin
                        w_ring_cnt_nxt = r_ring_cnt + RW'(1);
                    end
                end
            end
            default: w_ring_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode     <= M_RUN;
            r_ring     <= R_IDLE;
            r_ring_cnt <= '0;
            r_presc    <= '0;
            r_h        <= 5'd0;
            r_m        <= 6'd0;
            r_s        <= 6'd0;
            r_ah       <= 5'd7;
            r_am       <= 6'd0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_ring     <= w_ring_nxt;
            r_ring_cnt <= w_ring_cnt_nxt;
            r_presc    <= w_presc_nxt;
            r_h        <= w_h_nxt;
            r_m        <= w_m_nxt;
            r_s        <= w_s_nxt;
            r_ah       <= w_ah_nxt;
            r_am       <= w_am_nxt;
        end
    end

    // Display stage: one cycle behind the time/alarm registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_disp <= '0;
        end else if (r_mode == M_SET_ALARM) begin
            r_disp <= to_secs(r_ah, r_am, 6'd0);
        end else begin
            r_disp <= to_secs(r_h, r_m, r_s);
        end
    end

    assign disp_time = r_disp;
    assign mode      = r_mode;
    assign ringing   = (r_ring == R_RING);

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: seconds-of-day reference model plus directed literal checks
// and a randomized button phase.
`timescale 1ns/1ps
module tb_time_keeper;

    localparam int CF  = 4;
    localparam int RS  = 3;
    localparam int DAY = 86400;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_hr   = 1'b0;
    logic        btn_min  = 1'b0;
    logic        btn_stop = 1'b0;
    logic [16:0] disp_time;
    logic [1:0]  mode;
    logic        ringing;

    int errors = 0;
    int checks = 0;

    time_keeper #(.CLK_FREQ(CF), .RING_SECS(RS)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_hr    (btn_hr),
        .btn_min   (btn_min),
        .btn_stop  (btn_stop),
        .disp_time (disp_time),
        .mode      (mode),
        .ringing   (ringing)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: time and alarm kept as seconds-of-day integers.
    int m_t = 0, m_al = 7 * 3600, m_mode = 0, m_ring = 0, m_ph = 0, m_rt = 0, m_disp = 0;
    int n_t, n_al, n_mode, n_disp;
    bit n_tick, n_match;

    function automatic int bump_hour(input int x);
        int h;
        h = x / 3600;
        return x + (((h + 1) % 24) - h) * 3600;
    endfunction

    function automatic int bump_min(input int x);
        int mm;
        mm = (x / 60) % 60;
        return x + (((mm + 1) % 60) - mm) * 60;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_t = 0; m_al = 7 * 3600; m_mode = 0; m_ring = 0; m_ph = 0; m_rt = 0; m_disp = 0;
        end else begin
            n_tick  = (m_mode != 1) && (m_ph == CF - 1);
            n_disp  = (m_mode == 2) ? m_al : m_t;
            n_t     = n_tick ? (m_t + 1) % DAY : m_t;
            n_al    = m_al;
            n_match = n_tick && (m_mode == 0) && (n_t == m_al);
            n_mode  = m_mode;
            if (btn_mode) n_mode = (m_mode + 1) % 3;
            else if (btn_hr) begin
                if (m_mode == 1) n_t = bump_hour(n_t);
                else if (m_mode == 2) n_al = bump_hour(n_al);
            end else if (btn_min) begin
                if (m_mode == 1) n_t = bump_min(n_t);
                else if (m_mode == 2) n_al = bump_min(n_al);
            end
            if (m_mode == 0 && n_mode == 1) n_t = n_t - (n_t % 60);
            m_ph = (m_mode == 1 || n_mode == 1) ? 0 : (m_ph + 1) % CF;
            if (m_ring == 0) begin
                if (n_match) begin m_ring = 1; m_rt = 0; end
            end else if (btn_stop || btn_mode) begin
                m_ring = 0;
            end else if (n_tick) begin
                m_rt++;
                if (m_rt == RS) m_ring = 0;
            end
            m_t = n_t; m_al = n_al; m_mode = n_mode; m_disp = n_disp;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("disp_time", int'(disp_time), m_disp);
            chk("mode", int'(mode), m_mode);
            chk("ringing", int'(ringing), m_ring);
            chk("disp_range", int'(disp_time <= 17'd86399), 1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int which, input int n);
        repeat (n) begin
            case (which)
                0: btn_mode = 1'b1;
                1: btn_hr   = 1'b1;
                2: btn_min  = 1'b1;
                default: btn_stop = 1'b1;
            endcase
            @(negedge clk);
            btn_mode = 1'b0; btn_hr = 1'b0; btn_min = 1'b0; btn_stop = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    // Alarm 00:01, time restarted from 00:00:00, back in RUN.
    task automatic setup_alarm_0001();
        do_reset();
        press(0, 2);
        press(1, 17);
        press(2, 1);
        press(0, 1);
        press(0, 3);
    endtask

    task automatic wait_ring(input string name);
        for (int i = 0; i < 600 && !ringing; i++) @(negedge clk);
        chk(name, int'(ringing), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int cnt;
        bit seen_max, seen_wrap;
        int prev;
        @(negedge clk);
        chk("reset_disp", int'(disp_time), 0);
        chk("reset_mode", int'(mode), 0);
        chk("reset_ring", int'(ringing), 0);

        // Basic count.
        do_reset();
        step(4);  chk("count_4clk", int'(disp_time), 0);
        step(1);  chk("count_5clk", int'(disp_time), 1);
        step(235); chk("count_240clk", int'(disp_time), 59);
        step(1);  chk("count_241clk", int'(disp_time), 60);

        // Set time: 25 hours -> 1, 61 minutes -> 1, frozen, priority.
        do_reset();
        press(0, 1); chk("set_mode", int'(mode), 1);
        press(1, 25);
        press(2, 61);
        step(2);  chk("set_time_val", int'(disp_time), 3660);
        step(20); chk("set_frozen", int'(disp_time), 3660);
        btn_mode = 1'b1; btn_hr = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0; btn_hr = 1'b0;
        @(negedge clk);
        chk("prio_mode", int'(mode), 2);
        chk("alarm_default", int'(disp_time), 25200);
        press(0, 1); chk("back_run", int'(mode), 0);

        // Midnight wrap from 23:59.
        do_reset();
        press(0, 1); press(1, 23); press(2, 59); press(0, 2);
        seen_max = 0; seen_wrap = 0; prev = int'(disp_time);
        for (int i = 0; i < 600 && !seen_wrap; i++) begin
            @(negedge clk);
            if (disp_time == 17'd86399) seen_max = 1;
            if (seen_max && disp_time == 17'd0) begin
                seen_wrap = 1;
                chk("wrap_prev", prev, 86399);
            end
            prev = int'(disp_time);
        end
        chk("wrap_seen", int'(seen_wrap), 1);

        // Alarm rings, stop button.
        setup_alarm_0001();
        wait_ring("alarm_ring");
        chk("alarm_disp_lag", int'(disp_time), 59);
        step(1); chk("alarm_disp", int'(disp_time), 60);
        btn_stop = 1'b1;
        @(negedge clk);
        btn_stop = 1'b0;
        chk("stop_ring", int'(ringing), 0);

        // Auto-stop after RS ticks; stop held across the match tick is ignored.
        setup_alarm_0001();
        btn_stop = 1'b1;
        wait_ring("stop_on_match");
        btn_stop = 1'b0;
        cnt = 0;
        while (ringing && cnt < 100) begin
            cnt++;
            step(1);
        end
        chk("ring_len", cnt, 4 * RS);
        press(3, 1);
        chk("stop_idle", int'(ringing), 0);
        chk("stop_idle_mode", int'(mode), 0);

        // Asynchronous reset mid-ring and in SET_ALARM.
        setup_alarm_0001();
        wait_ring("ring_before_rst");
        #3 reset = 1'b0;
        #1;
        chk("arst_ring_disp", int'(disp_time), 0);
        chk("arst_ring_mode", int'(mode), 0);
        chk("arst_ring_ring", int'(ringing), 0);
        @(negedge clk); reset = 1'b1;
        press(0, 2);
        step(1);
        chk("alarm_mode", int'(mode), 2);
        chk("alarm_view", int'(disp_time), 25200);
        #3 reset = 1'b0;
        #1;
        chk("arst_alarm_disp", int'(disp_time), 0);
        chk("arst_alarm_mode", int'(mode), 0);
        @(negedge clk); reset = 1'b1;

        // Randomized buttons with occasional resets.
        setup_alarm_0001();
        for (int i = 0; i < 6000; i++) begin
            btn_mode = ($urandom_range(0, 79) == 0);
            btn_hr   = ($urandom_range(0, 5) == 0);
            btn_min  = ($urandom_range(0, 5) == 0);
            btn_stop = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2999) == 0) #2 reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
        end
        btn_mode = 1'b0; btn_hr = 1'b0; btn_min = 1'b0; btn_stop = 1'b0;
        step(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
